// File: rtl/imem_fetch_sequencer.sv
// Fetch sequencer for a 1-cycle-latency instruction RAM: start-to-first-valid is 2 edges, then 1 instr/cycle.
// A stall holds and replays the presented address. FETCH_WATCHDOG_EN adds an accept-count halt.
module imem_fetch_sequencer #(
  parameter logic [9:0]  PROG0_BASE = 10'd0,
  parameter logic [9:0]  PROG1_BASE = 10'd15,
  parameter logic [9:0]  PROG2_BASE = 10'd25,
  parameter logic [15:0] WD_LIMIT   = 16'd255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  prog_sel,
  input  logic        stall,
  input  logic        redirect,
  input  logic [9:0]  redirect_addr,
  input  logic        halt_req,
  output logic [9:0]  mem_addr,
  input  logic [31:0] mem_instr,
  output logic [31:0] instr,
  output logic [9:0]  instr_pc,
  output logic        instr_valid,
  output logic        busy,
  output logic        done,
  output logic        wd_trip
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  pc_q, pc_d;
  logic [9:0]  instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic        wd_trip_q, wd_trip_d;

  logic        accept;
  logic        redirect_take;
  logic        start_ok;
  logic [9:0]  start_base;
  logic        wd_hit;

  assign accept        = instr_valid_q & ~stall;
  assign redirect_take = redirect & accept;
  assign start_ok      = start & (prog_sel != 2'd3);

  always_comb begin
    start_base = PROG0_BASE;
    case (prog_sel)
      2'd1:    start_base = PROG1_BASE;
      2'd2:    start_base = PROG2_BASE;
      default: start_base = PROG0_BASE;
    endcase
  end

`ifdef FETCH_WATCHDOG_EN
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic [15:0] wd_cnt_inc;

  assign wd_cnt_inc = wd_cnt_q + 16'd1;
  assign wd_hit     = (state_q == ST_RUN) & accept & (wd_cnt_inc == WD_LIMIT);

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if ((state_q != ST_RUN) && start_ok) begin
      wd_cnt_d = 16'd0;
    end else if ((state_q == ST_RUN) && accept) begin
      wd_cnt_d = wd_cnt_inc;
    end
  end
`else
  logic unused_wd_limit;

  assign unused_wd_limit = ^WD_LIMIT;
  assign wd_hit          = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    wd_trip_d     = wd_trip_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          state_d       = ST_RUN;
          pc_d          = start_base;
          instr_valid_d = 1'b0;
          wd_trip_d     = 1'b0;
        end
      end
      ST_RUN: begin
        if (halt_req || wd_hit) begin
          state_d       = ST_DONE;
          instr_valid_d = 1'b0;
          if (wd_hit) begin
            wd_trip_d = 1'b1;
          end
        end else if (redirect_take) begin
          // Target is presented on the next edge, so its fetch goes out this cycle.
          instr_pc_d    = redirect_addr;
          pc_d          = redirect_addr + 10'd1;
          instr_valid_d = 1'b1;
        end else if (!(instr_valid_q && stall)) begin
          instr_pc_d    = pc_q;
          pc_d          = pc_q + 10'd1;
          instr_valid_d = 1'b1;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        instr_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= 10'd0;
      instr_pc_q    <= 10'd0;
      instr_valid_q <= 1'b0;
      wd_trip_q     <= 1'b0;
`ifdef FETCH_WATCHDOG_EN
      wd_cnt_q      <= 16'd0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      wd_trip_q     <= wd_trip_d;
`ifdef FETCH_WATCHDOG_EN
      wd_cnt_q      <= wd_cnt_d;
`endif
    end
  end

  // Replaying instr_pc during a stall keeps mem_instr aligned with the held instruction.
  always_comb begin
    mem_addr = pc_q;
    if (redirect_take) begin
      mem_addr = redirect_addr;
    end else if (instr_valid_q && stall) begin
      mem_addr = instr_pc_q;
    end
  end

  assign instr       = instr_valid_q ? mem_instr : 32'd0;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);
  assign wd_trip     = wd_trip_q;

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Randomized bench for imem_fetch_sequencer against a cycle-level model of the fetch rules.
module tb_imem_fetch_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  prog_sel;
  logic        stall;
  logic        redirect;
  logic [9:0]  redirect_addr;
  logic        halt_req;
  logic [9:0]  mem_addr;
  logic [31:0] mem_instr = 32'd0;
  logic [31:0] instr;
  logic [9:0]  instr_pc;
  logic        instr_valid;
  logic        busy;
  logic        done;
  logic        wd_trip;

  localparam int WD_LIM = 4;

  imem_fetch_sequencer #(
    .PROG0_BASE (10'd0),
    .PROG1_BASE (10'd15),
    .PROG2_BASE (10'd25),
    .WD_LIMIT   (16'd4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .prog_sel      (prog_sel),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .halt_req      (halt_req),
    .mem_addr      (mem_addr),
    .mem_instr     (mem_instr),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .busy          (busy),
    .done          (done),
    .wd_trip       (wd_trip)
  );

  always #5 clock = ~clock;

  logic [31:0] ram [1024];
  always @(posedge clock) mem_instr <= ram[mem_addr];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: 0 = idle, 1 = running, 2 = done
  int m_state, m_next, m_pc, m_count;
  bit m_valid, m_trip;

  function automatic int base_of(input int s);
    if (s == 1) return 15;
    if (s == 2) return 25;
    return 0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_next = 0; m_pc = 0; m_count = 0; m_valid = 0; m_trip = 0;
  endtask

  task automatic model_edge(input bit st, input int sel, input bit stl, input bit rd,
                            input int ra, input bit hl);
    bit acc, hit;
    acc = m_valid && !stl;
    hit = 0;
    if (m_state != 1) begin
      if (st && sel != 3) begin
        m_state = 1; m_next = base_of(sel); m_valid = 0; m_trip = 0; m_count = 0;
      end
    end else begin
`ifdef FETCH_WATCHDOG_EN
      if (acc) begin
        m_count = (m_count + 1) % 65536;
        hit = (m_count == WD_LIM);
      end
`endif
      if (hl || hit) begin
        m_state = 2; m_valid = 0;
        if (hit) m_trip = 1;
      end else if (rd && acc) begin
        m_pc = ra; m_next = (ra + 1) % 1024; m_valid = 1;
      end else if (!(m_valid && stl)) begin
        m_pc = m_next; m_next = (m_next + 1) % 1024; m_valid = 1;
      end
    end
  endtask

  task automatic compare_all();
    int exp_addr;
    logic [9:0] idx;
    if (redirect && m_valid && !stall) exp_addr = int'(redirect_addr);
    else if (m_valid && stall)         exp_addr = m_pc;
    else                               exp_addr = m_next;
    idx = m_pc[9:0];
    check_eq("mem_addr", {22'd0, mem_addr}, exp_addr);
    check_eq("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
    check_eq("instr_pc", {22'd0, instr_pc}, m_pc);
    check_eq("instr", instr, m_valid ? ram[idx] : 32'd0);
    check_eq("busy", {31'd0, busy}, (m_state == 1) ? 32'd1 : 32'd0);
    check_eq("done", {31'd0, done}, (m_state == 2) ? 32'd1 : 32'd0);
    check_eq("wd_trip", {31'd0, wd_trip}, {31'd0, m_trip});
  endtask

  task automatic cycle(input bit st, input int sel, input bit stl, input bit rd,
                       input int ra, input bit hl);
    start = st; prog_sel = 2'(sel); stall = stl; redirect = rd;
    redirect_addr = 10'(ra); halt_req = hl;
    #1;
    compare_all();
    @(posedge clock);
    model_edge(st, sel, stl, rd, ra, hl);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic async_reset();
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    check_eq("arst_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("arst_addr", {22'd0, mem_addr}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = $urandom;
    ram[0] = 32'hA81E0000;
    reset = 1'b1; start = 0; prog_sel = 0; stall = 0; redirect = 0;
    redirect_addr = 0; halt_req = 0;
    model_reset();
    #12;
    compare_all();
    @(posedge clock);
    #1;
    reset = 1'b0;

    cycle(1, 0, 0, 0, 0, 0);
    check_eq("start_addr", {22'd0, mem_addr}, 32'd0);
    idle(1);
    check_eq("first_pc", {22'd0, instr_pc}, 32'd0);
    check_eq("first_instr", instr, 32'hA81E0000);
    idle(3);
`ifndef FETCH_WATCHDOG_EN
    check_eq("seq_pc", {22'd0, instr_pc}, 32'd3);
`endif
    cycle(0, 0, 0, 0, 0, 1);
    check_eq("halt_done", {31'd0, done}, 32'd1);
    check_eq("halt_valid", {31'd0, instr_valid}, 32'd0);

    cycle(1, 1, 0, 0, 0, 0);
    idle(3);
    check_eq("p1_pc", {22'd0, instr_pc}, 32'd17);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, 0, 0, 0);
      check_eq("stall_pc", {22'd0, instr_pc}, 32'd17);
    end
    idle(1);
    check_eq("unstall_pc", {22'd0, instr_pc}, 32'd18);

    cycle(0, 0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0, 0);
    idle(11);
`ifndef FETCH_WATCHDOG_EN
    check_eq("pre_redir_pc", {22'd0, instr_pc}, 32'd10);
    cycle(0, 0, 0, 1, 6, 0);
    check_eq("redir_pc", {22'd0, instr_pc}, 32'd6);
    check_eq("redir_valid", {31'd0, instr_valid}, 32'd1);
    idle(1);
    check_eq("redir_next", {22'd0, instr_pc}, 32'd7);
    cycle(0, 0, 1, 1, 100, 0);
    check_eq("redir_stall", {22'd0, instr_pc}, 32'd7);
    idle(1);
    check_eq("pre_halt_pc", {22'd0, instr_pc}, 32'd8);
    cycle(0, 0, 0, 0, 0, 1);
    check_eq("halt8_done", {31'd0, done}, 32'd1);
    check_eq("halt8_valid", {31'd0, instr_valid}, 32'd0);
    cycle(1, 2, 0, 0, 0, 0);
    idle(1);
    check_eq("restart_pc", {22'd0, instr_pc}, 32'd25);
    cycle(0, 0, 0, 1, 1022, 0);
    idle(2);
    check_eq("wrap_pc", {22'd0, instr_pc}, 32'd0);
    idle(4);
    check_eq("no_wd_valid", {31'd0, instr_valid}, 32'd1);
    check_eq("no_wd_trip", {31'd0, wd_trip}, 32'd0);
`else
    cycle(0, 0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0, 0);
    idle(6);
    check_eq("wd_done", {31'd0, done}, 32'd1);
    check_eq("wd_trip_set", {31'd0, wd_trip}, 32'd1);
    cycle(1, 0, 0, 0, 0, 0);
    check_eq("wd_trip_clr", {31'd0, wd_trip}, 32'd0);
`endif

    idle(2);
    async_reset();
    cycle(1, 3, 0, 0, 0, 0);
    idle(1);
    check_eq("sel3_busy", {31'd0, busy}, 32'd0);
    check_eq("sel3_valid", {31'd0, instr_valid}, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      int ra;
      ra = ($urandom_range(0, 9) == 0) ? 1023 : int'($urandom_range(0, 1023));
      cycle($urandom_range(0, 7) == 0, int'($urandom_range(0, 3)),
            $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, ra,
            $urandom_range(0, 39) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imem_fetch_sequencer.md
# imem_fetch_sequencer

Fetch controller that sequences the 32-bit synchronous instruction memory (10-bit address, one-cycle read latency) for the MIPS core. It selects one of the stored programs by base address, streams instructions to the decode stage at one per cycle, and applies stalls, taken-branch/jump redirects and halt. It sits between the program-select user inputs, the instruction memory and the decode stage.

## Interface
- PROG0_BASE, 0: start address for prog_sel=0 (fibonacci)
- PROG1_BASE, 15: start address for prog_sel=1 (factorial)
- PROG2_BASE, 25: start address for prog_sel=2 (synthetic)
- WD_LIMIT, 255: accepted-instruction limit, 16-bit (used only with the watchdog)

- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  begin the selected program (level sampled at the edge)
- prog_sel  in  2  program select; 3 is reserved
- stall  in  1  decode not accepting the presented instruction
- redirect  in  1  presented instruction is a taken branch/jump
- redirect_addr  in  10  target of the redirect
- halt_req  in  1  stop fetching
- mem_addr  out  10  address to instruction memory (combinational)
- mem_instr  in  32  instruction memory read data (RAM[address sampled at previous edge])
- instr  out  32  presented instruction, equal to mem_instr when instr_valid, else 0
- instr_pc  out  10  address of the presented instruction
- instr_valid  out  1  instr/instr_pc valid
- busy  out  1  state RUN
- done  out  1  state DONE
- wd_trip  out  1  watchdog halt flag, sticky until the next start

## Operation
- States: IDLE (reset), RUN, DONE. busy = RUN, done = DONE.
- Registers: pc (next address to issue), instr_pc, instr_valid, state, plus the watchdog count when enabled.
- Accept = instr_valid & ~stall.
- mem_addr priority: (redirect & accept) ? redirect_addr : (instr_valid & stall) ? instr_pc : pc. During a stall the held address is replayed, so mem_instr stays equal to RAM[instr_pc].
- IDLE/DONE, start=1, prog_sel 0/1/2: pc <= base, instr_valid <= 0, go to RUN, clear wd_trip. With prog_sel=3, start is ignored.
- RUN edge priority: halt_req > redirect > stall > sequential.
  - halt_req: go to DONE, instr_valid <= 0.
  - redirect & accept: instr_pc <= redirect_addr, pc <= redirect_addr+1, instr_valid <= 1. There is no bubble. A redirect while stalled is ignored; decode holds it until accepted.
  - instr_valid & stall: all registers hold.
  - Otherwise: instr_pc <= pc, pc <= pc+1, instr_valid <= 1.
- start during RUN is ignored.
- pc arithmetic is 10-bit modulo: 1023+1 = 0, and redirect_addr=1023 gives pc=0.

## Timing
- Reset (asynchronous, immediate, no clock needed): state IDLE, pc=0, instr_pc=0, instr_valid=0, instr=0, busy=0, done=0, wd_trip=0, mem_addr=0.
- Start latency: start sampled at edge E0, mem_addr=base during the next cycle, instr_valid=1 with instr_pc=base after E1.
- Throughput: 1 instruction per cycle when stall=0.
- After stall deasserts, instr_pc advances at the very next edge.
- halt_req sampled at edge E: done=1 and instr_valid=0 after E.
- Reset mid-RUN drops instr_valid combinationally with the reset assertion.

## Configuration
- FETCH_WATCHDOG_EN defined:
  - A 16-bit counter clears on start and increments on each accept.
  - At the edge where an accept makes the count equal WD_LIMIT, the block goes to DONE, instr_valid <= 0 and wd_trip <= 1.
  - halt_req on that same edge also goes to DONE, and wd_trip is still set.
- FETCH_WATCHDOG_EN undefined: no counter, wd_trip is tied 0, and the block runs until halt_req or reset.

## Test plan
- Reset, start with prog_sel=0, stall=0: mem_addr 0,1,2,…; instr_valid rises after the second edge with instr_pc=0 and instr=32'hA81E0000, then instr_pc=1,2,3 on consecutive cycles.
- Start with prog_sel=1: first instr_pc=15, then 16, 17. Start with prog_sel=3 from IDLE: busy stays 0 and instr_valid stays 0.
- Stall for 3 cycles while instr_pc=17: instr_pc=17 and instr held for 3 cycles, mem_addr=17; then instr_pc=18 on the first cycle after release.
- Redirect at instr_pc=10 with redirect_addr=6: next cycle instr_pc=6, then 7, with no invalid cycle. Redirect with stall=1: ignored and held.
- halt_req at instr_pc=8: next cycle done=1, instr_valid=0; a later start restarts from base. Asynchronous reset mid-RUN: all outputs are 0 before the next edge.
- FETCH_WATCHDOG_EN with WD_LIMIT=4: after 4 accepts, done=1 and wd_trip=1; a new start clears wd_trip. Without the macro, fetching continues past 4 and wd_trip stays 0.
